param_serial_mult: RTL and testbench

PARAM_SERIAL_MULT -- requirements
Module: param_serial_mult

---
 rtl/serial_mult_pkg.sv | 22 ++
 rtl/serial_mult_core.sv | 67 ++++++
 rtl/param_serial_mult.sv | 183 ++++++++++++++++++
 tb/tb_param_serial_mult.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// Shared types and helpers for the bit-serial fixed-point multiplier.
package serial_mult_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COMPUTE = 1'b1
    } state_e;

    function automatic int nb_counter(input int nb_data_in);
        return $clog2(2 * nb_data_in);
    endfunction

    // Largest positive two's-complement word of the given width, low bits of the result
    function automatic logic [31:0] sat_max(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/serial_mult_core.sv
// Carry-save serial-serial multiplier: operands arrive LSB first, one exact
// product bit leaves per step; the MSB row carries the two's-complement correction.
module serial_mult_core
    import serial_mult_pkg::*;
#(
    parameter int NB_DATA_IN = 8,
    parameter int NB_COUNTER = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_step,
    input  logic                  i_first,
    input  logic [NB_COUNTER-1:0] i_idx,
    input  logic                  i_data_a,
    input  logic                  i_data_b,
    output logic                  o_bit
);

    localparam int NB_PROD = 2 * NB_DATA_IN;

    logic [NB_DATA_IN-1:0] a_bits_r, b_bits_r, a_prev_s, b_prev_s, a_next_s, b_next_s;
    logic [NB_PROD-1:0]    sum_r, carry_r, sum_in_s, carry_in_s;
    logic [NB_PROD-1:0]    cross_s, diag_s, row_s, s_full_s, c_full_s;
    logic                  sample_s, last_row_s;

    // Row generation and 3:2 compression; the window is re-aligned by one bit per step
    always_comb begin
        a_prev_s   = i_first ? {NB_DATA_IN{1'b0}} : a_bits_r;
        b_prev_s   = i_first ? {NB_DATA_IN{1'b0}} : b_bits_r;
        sum_in_s   = i_first ? {NB_PROD{1'b0}} : sum_r;
        carry_in_s = i_first ? {NB_PROD{1'b0}} : carry_r;
        sample_s   = (i_idx < NB_COUNTER'(NB_DATA_IN));
        last_row_s = (i_idx == NB_COUNTER'(NB_DATA_IN - 1));
        cross_s    = (i_data_a ? {{NB_DATA_IN{1'b0}}, b_prev_s} : {NB_PROD{1'b0}})
                   + (i_data_b ? {{NB_DATA_IN{1'b0}}, a_prev_s} : {NB_PROD{1'b0}});
        diag_s     = NB_PROD'(i_data_a & i_data_b) << i_idx;
        // Cross terms with exactly one sign bit carry negative weight
        if (!sample_s) begin
            row_s = {NB_PROD{1'b0}};
        end else if (last_row_s) begin
            row_s = diag_s - cross_s;
        end else begin
            row_s = diag_s + cross_s;
        end
        a_next_s   = a_prev_s | (NB_DATA_IN'(i_data_a & sample_s) << i_idx);
        b_next_s   = b_prev_s | (NB_DATA_IN'(i_data_b & sample_s) << i_idx);
        s_full_s   = sum_in_s ^ carry_in_s ^ row_s;
        c_full_s   = (sum_in_s & carry_in_s) | (sum_in_s & row_s) | (carry_in_s & row_s);
        o_bit      = s_full_s[0];
    end

    // Operand history and carry-save accumulator
    always_ff @(posedge clk) begin
        if (i_rst) begin
            a_bits_r <= {NB_DATA_IN{1'b0}};
            b_bits_r <= {NB_DATA_IN{1'b0}};
            sum_r    <= {NB_PROD{1'b0}};
            carry_r  <= {NB_PROD{1'b0}};
        end else if (i_step) begin
            a_bits_r <= a_next_s;
            b_bits_r <= b_next_s;
            sum_r    <= {1'b0, s_full_s[NB_PROD-1:1]};
            carry_r  <= c_full_s;
        end
    end

endmodule

// File: rtl/param_serial_mult.sv
// Bit-serial signed fixed-point multiplier with resize/saturation and serial output.
// Define SERIAL_MULT_ROUND_EN for round-half-up; otherwise the product is truncated.
module param_serial_mult
    import serial_mult_pkg::*;
#(
    parameter int NB_DATA_IN   = 8,
    parameter int NBF_DATA_IN  = 6,
    parameter int NB_DATA_OUT  = 8,
    parameter int NBF_DATA_OUT = 6
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_start,
    input  logic i_data_a,
    input  logic i_data_b,
    output logic o_ready,
    output logic o_data,
    output logic o_valid,
    output logic o_sof,
    output logic o_sat
);

    localparam int NB_PROD    = 2 * NB_DATA_IN;
    localparam int NB_EXT     = NB_PROD + 1;
    localparam int NB_COUNTER = nb_counter(NB_DATA_IN);
    localparam int NB_REM     = $clog2(NB_DATA_OUT + 1);
    localparam int SHIFT      = 2 * NBF_DATA_IN - NBF_DATA_OUT;
    localparam logic [NB_COUNTER-1:0]  CNT_LAST = NB_COUNTER'(NB_PROD - 1);
    localparam logic [NB_COUNTER-1:0]  CNT_LOAD = NB_COUNTER'(NB_PROD - 2);
    localparam logic [NB_DATA_OUT-1:0] WORD_MAX = NB_DATA_OUT'(sat_max(NB_DATA_OUT));
    localparam logic [NB_DATA_OUT-1:0] WORD_MIN = NB_DATA_OUT'(sat_min(NB_DATA_OUT));

    state_e                  state_r, state_next_s;
    logic [NB_COUNTER-1:0]   cnt_r, cnt_next_s, idx_s;
    logic                    start_s, step_s, last_s, core_bit_s;
    logic [NB_PROD-2:0]      prod_r;
    logic [NB_PROD-1:0]      prod_full_s;
    logic [NB_EXT-1:0]       ext_s, rounded_s, kept_s;
    logic [NB_DATA_OUT-1:0]  word_s, sr_r;
    logic                    fits_s, sat_s;
    logic [NB_REM-1:0]       rem_r;
    logic                    data_r, valid_r, sof_r, sat_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {NB_COUNTER{1'b0}};
        end else if (i_en) begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_next_s = ST_COMPUTE;
                end else begin
                    state_next_s = ST_IDLE;
                end
                cnt_next_s = {NB_COUNTER{1'b0}};
            end
            ST_COMPUTE: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {NB_COUNTER{1'b0}};
                end else begin
                    cnt_next_s   = cnt_r + NB_COUNTER'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {NB_COUNTER{1'b0}};
            end
        endcase
    end

    // FSM outputs: the start cycle itself is product step 0
    always_comb begin
        o_ready = (state_r == ST_IDLE);
        start_s = o_ready & i_start & i_en;
        if (state_r == ST_COMPUTE) begin
            idx_s  = cnt_r + NB_COUNTER'(1);
            step_s = i_en & (cnt_r != CNT_LAST);
            last_s = i_en & (cnt_r == CNT_LOAD);
        end else begin
            idx_s  = {NB_COUNTER{1'b0}};
            step_s = start_s;
            last_s = 1'b0;
        end
    end

    serial_mult_core #(
        .NB_DATA_IN (NB_DATA_IN),
        .NB_COUNTER (NB_COUNTER)
    ) u_core (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_step   (step_s),
        .i_first  (start_s),
        .i_idx    (idx_s),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_bit    (core_bit_s)
    );

    // Product bits collected LSB first
    always_ff @(posedge clk) begin
        if (i_rst) begin
            prod_r <= {(NB_PROD - 1){1'b0}};
        end else if (step_s) begin
            prod_r <= {core_bit_s, prod_r[NB_PROD-2:1]};
        end
    end

    // Resize: optional round, arithmetic discard, range check against the output format
    always_comb begin
        prod_full_s = {core_bit_s, prod_r};
        ext_s       = {prod_full_s[NB_PROD-1], prod_full_s};
`ifdef SERIAL_MULT_ROUND_EN
        if (SHIFT > 0) begin
            rounded_s = ext_s + (NB_EXT'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0));
        end else begin
            rounded_s = ext_s;
        end
`else
        rounded_s = ext_s;
`endif
        kept_s = NB_EXT'($signed(rounded_s) >>> SHIFT);
        fits_s = (&kept_s[NB_EXT-1:NB_DATA_OUT-1]) | ~(|kept_s[NB_EXT-1:NB_DATA_OUT-1]);
        if (fits_s) begin
            word_s = kept_s[NB_DATA_OUT-1:0];
        end else if (kept_s[NB_EXT-1]) begin
            word_s = WORD_MIN;
        end else begin
            word_s = WORD_MAX;
        end
        sat_s = ~fits_s;
    end

    // Output serialiser, runs alongside the next frame's computation
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sr_r    <= {NB_DATA_OUT{1'b0}};
            rem_r   <= {NB_REM{1'b0}};
            data_r  <= 1'b0;
            valid_r <= 1'b0;
            sof_r   <= 1'b0;
            sat_r   <= 1'b0;
        end else if (i_en) begin
            if (last_s) begin
                sr_r    <= {1'b0, word_s[NB_DATA_OUT-1:1]};
                rem_r   <= NB_REM'(NB_DATA_OUT - 1);
                data_r  <= word_s[0];
                valid_r <= 1'b1;
                sof_r   <= 1'b1;
                sat_r   <= sat_s;
            end else if (rem_r != {NB_REM{1'b0}}) begin
                sr_r    <= {1'b0, sr_r[NB_DATA_OUT-1:1]};
                rem_r   <= rem_r - NB_REM'(1);
                data_r  <= sr_r[0];
                valid_r <= 1'b1;
                sof_r   <= 1'b0;
            end else begin
                valid_r <= 1'b0;
                sof_r   <= 1'b0;
            end
        end
    end

    // A presented bit is consumed only on an enabled cycle
    assign o_data  = data_r;
    assign o_sat   = sat_r;
    assign o_valid = valid_r & i_en;
    assign o_sof   = sof_r & i_en;

endmodule

// File: tb/tb_param_serial_mult.sv
// Directed bench for param_serial_mult at default parameters (S8.6 x S8.6 -> S8.6).
module tb_param_serial_mult;

    logic clk, i_rst, i_en, i_start, i_data_a, i_data_b;
    logic o_ready, o_data, o_valid, o_sof, o_sat;

    param_serial_mult dut (
        .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_sat(o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_MULT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] w; logic s; } vec_t;
    typedef struct { logic [7:0] w; logic s; } out_t;
    localparam int NV = 17;
    vec_t vt [NV];
    out_t outq [$];

    int n_vec = 0, n_err = 0, cyc = 0, sof_cyc = 0;
    int frame_err = 0, gate_err = 0, hold_err = 0, nbits = 0;
    logic [7:0] cur_w = 8'h00;
    logic cur_s = 1'b0, prev_en = 1'b0, prev_rst = 1'b1, prev_data = 1'b0, prev_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: assembles words and checks framing, gating and hold behaviour
    always @(negedge clk) begin
        if (i_rst) begin
            nbits = 0;
        end else begin
            if (!i_en && (o_valid || o_sof)) gate_err++;
            if (!prev_en && !prev_rst && (o_data !== prev_data || o_sat !== prev_sat)) hold_err++;
            if (o_valid) begin
                if (o_sof) begin
                    if (nbits != 0) frame_err++;
                    nbits = 0; cur_s = o_sat; sof_cyc = cyc;
                end else if (nbits == 0 || o_sat !== cur_s) begin
                    frame_err++;
                end
                if (nbits < 8) cur_w[nbits] = o_data;
                nbits++;
                if (nbits == 8) begin
                    outq.push_back('{cur_w, cur_s});
                    nbits = 0;
                end
            end else if (i_en && nbits != 0) begin
                frame_err++;
            end
        end
        prev_en = i_en; prev_rst = i_rst; prev_data = o_data; prev_sat = o_sat;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++; n_err++;
        $display("FAIL %s: nothing happened within the cycle budget", name);
    endtask

    // Drive one frame LSB first; stray i_start pulses while busy when rand_en is set
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input bit rand_en, output int st);
        int k = 0, g = 0;
        st = 0;
        while (k < 8 && g < 400) begin
            @(posedge clk); #1; g++;
            i_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            i_data_a = a[k]; i_data_b = b[k];
            if (k == 0) begin
                i_start = 1'b1;
                if (o_ready && i_en) begin k = 1; st = cyc; end
            end else begin
                i_start = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
                if (i_en) k++;
            end
        end
        if (k < 8) timeout("send_frame");
    endtask

    task automatic wait_words(input int n, input bit rand_en);
        int g = 0;
        while (outq.size() < n && g < 400) begin
            @(posedge clk); #1; g++;
            i_start = 1'b0;
            i_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (outq.size() < n) timeout("wait_words");
    endtask

    task automatic expect_word(input string name, input logic [7:0] w, input logic s);
        out_t o;
        if (outq.size() == 0) begin
            timeout(name);
        end else begin
            o = outq.pop_front();
            check({name, " word"}, 16'(o.w), 16'(w));
            check({name, " sat"}, 16'(o.s), 16'(s));
        end
    endtask

    initial begin
        int st, g;
        i_rst = 1'b1; i_en = 1'b0; i_start = 1'b0; i_data_a = 1'b0; i_data_b = 1'b0;
        vt[0]  = '{8'h20, 8'h20, 8'h10, 1'b0};
        vt[1]  = '{8'h60, 8'h60, 8'h7F, 1'b1};
        vt[2]  = '{8'h80, 8'h60, 8'h80, 1'b1};
        vt[3]  = '{8'h80, 8'h80, 8'h7F, 1'b1};
        vt[4]  = '{8'h01, 8'h20, RND ? 8'h01 : 8'h00, 1'b0};
        vt[5]  = '{8'hFF, 8'h20, RND ? 8'h00 : 8'hFF, 1'b0};
        vt[6]  = '{8'h40, 8'h40, 8'h40, 1'b0};
        vt[7]  = '{8'hC0, 8'h40, 8'hC0, 1'b0};
        vt[8]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1};
        vt[9]  = '{8'h30, 8'hE0, 8'hE8, 1'b0};
        vt[10] = '{8'h55, 8'h0B, RND ? 8'h0F : 8'h0E, 1'b0};
        vt[11] = '{8'h9C, 8'h27, 8'hC3, 1'b0};
        vt[12] = '{8'h00, 8'h80, 8'h00, 1'b0};
        vt[13] = '{8'h80, 8'h7F, 8'h80, 1'b1};
        vt[14] = '{8'h80, 8'h01, 8'hFE, 1'b0};
        vt[15] = '{8'h5A, 8'h5A, RND ? 8'h7F : 8'h7E, 1'b0};
        vt[16] = '{8'h60, 8'h55, 8'h7F, RND};

        repeat (3) @(posedge clk);
        #1; i_rst = 1'b0; i_en = 1'b1;
        @(negedge clk);
        check("reset o_ready", 16'(o_ready), 16'd1);
        check("reset o_valid", 16'(o_valid), 16'd0);
        check("reset o_sof", 16'(o_sof), 16'd0);
        check("reset o_data", 16'(o_data), 16'd0);
        check("reset o_sat", 16'(o_sat), 16'd0);

        for (int i = 0; i < NV; i++) begin
            send_frame(vt[i].a, vt[i].b, 1'b0, st);
            wait_words(1, 1'b0);
            if (i == 0) check("sof latency", 16'(sof_cyc - st), 16'd16);
            expect_word($sformatf("vec%0d %h*%h", i, vt[i].a, vt[i].b), vt[i].w, vt[i].s);
        end

        // back-to-back frames, random enable, i_start pulsed while busy
        send_frame(8'h20, 8'h20, 1'b1, st);
        send_frame(8'h80, 8'h60, 1'b1, st);
        send_frame(8'h55, 8'h0B, 1'b1, st);
        wait_words(3, 1'b1);
        check("b2b count", 16'(outq.size()), 16'd3);
        expect_word("b2b0", 8'h10, 1'b0);
        expect_word("b2b1", 8'h80, 1'b1);
        expect_word("b2b2", RND ? 8'h0F : 8'h0E, 1'b0);

        // reset mid-COMPUTE: frame is dropped
        send_frame(8'h7F, 8'h7F, 1'b0, st);
        @(posedge clk); #1; i_rst = 1'b1; i_start = 1'b0;
        @(posedge clk); #1; i_rst = 1'b0;
        @(negedge clk);
        check("rst compute ready", 16'(o_ready), 16'd1);
        repeat (30) @(posedge clk);
        check("rst compute no output", 16'(outq.size()), 16'd0);

        // reset mid-output: o_valid drops next cycle, no partial word
        send_frame(8'h60, 8'h60, 1'b0, st);
        g = 0;
        while (!o_valid && g < 100) begin @(posedge clk); #1; i_start = 1'b0; g++; end
        if (!o_valid) timeout("wait o_valid");
        repeat (3) @(posedge clk);
        #1; i_rst = 1'b1;
        @(posedge clk); #1; i_rst = 1'b0;
        @(negedge clk);
        check("rst output o_valid", 16'(o_valid), 16'd0);
        check("rst output o_ready", 16'(o_ready), 16'd1);
        check("rst output o_sat", 16'(o_sat), 16'd0);
        check("rst output no word", 16'(outq.size()), 16'd0);
        send_frame(8'h20, 8'h20, 1'b0, st);
        wait_words(1, 1'b0);
        expect_word("after reset", 8'h10, 1'b0);

        repeat (5) @(posedge clk);
        check("framing errors", 16'(frame_err), 16'd0);
        check("enable gating errors", 16'(gate_err), 16'd0);
        check("hold errors", 16'(hold_err), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
